// File: rtl/fifo_flex.sv
// Parametrised single-clock FIFO with registered or FWFT read,
// occupancy count, threshold flags, flush and sticky error flags.
module fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [DATA_WIDTH-1:0]    w_data,
  input  logic                     re,
  output logic [DATA_WIDTH-1:0]    r_data,
  input  logic                     flush,
  input  logic                     clr_err,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
  localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovf;
  logic                  r_unf;

  logic w_rd_ok;
  logic w_wr_ok;
  logic w_op;

  // A full FIFO still takes a write when a read frees a slot this edge.
  assign w_rd_ok = re && (r_count != '0);
  assign w_wr_ok = we && ((r_count != C_DEPTH) || w_rd_ok);
  assign w_op    = !rst && !flush;

  always_ff @(posedge clk) begin
    if (w_op && w_wr_ok) begin
      r_mem[r_wptr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_wr_ok && !w_rd_ok) begin
        r_count <= r_count + 1'b1;
      end else if (w_rd_ok && !w_wr_ok) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Flush leaves the error flags alone; clr_err beats a same-edge set.
  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (!flush) begin
      if (we && !w_wr_ok) begin
        r_ovf <= 1'b1;
      end
      if (re && !w_rd_ok) begin
        r_unf <= 1'b1;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign r_data = r_mem[r_rptr];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_rdata;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rdata <= '0;
        end else if (w_op && w_rd_ok) begin
          r_rdata <= r_mem[r_rptr];
        end
      end
      assign r_data = r_rdata;
    end
  endgenerate

  assign count        = r_count;
  assign empty        = (r_count == '0);
  assign full         = (r_count == C_DEPTH);
  assign almost_empty = (r_count <= C_AE);
  assign almost_full  = (r_count >= C_AF);
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_fifo_flex.sv
// Scoreboard bench for fifo_flex: registered-read and FWFT instances,
// DEPTH=16, AF_THRESH=14, AE_THRESH=2.
module tb_fifo_flex;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // registered-read instance
  logic          rst, we, re, flush, clr_err;
  logic [DW-1:0] w_data, r_data;
  logic          empty, full, aempty, afull, ovf, unf;
  logic [4:0]    count;

  fifo_flex #(
    .DATA_WIDTH(DW), .DEPTH(DP), .FWFT(0),
    .AF_THRESH(AF), .AE_THRESH(AE)
  ) u_dut (
    .clk(clk), .rst(rst), .we(we), .w_data(w_data),
    .re(re), .r_data(r_data), .flush(flush), .clr_err(clr_err),
    .empty(empty), .full(full), .almost_empty(aempty),
    .almost_full(afull), .count(count),
    .overflow(ovf), .underflow(unf)
  );

  // FWFT instance
  logic          f_rst, f_we, f_re;
  logic [DW-1:0] f_wd, f_rd;
  logic          f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
  logic [4:0]    f_count;

  fifo_flex #(
    .DATA_WIDTH(DW), .DEPTH(DP), .FWFT(1),
    .AF_THRESH(AF), .AE_THRESH(AE)
  ) u_fwft (
    .clk(clk), .rst(f_rst), .we(f_we), .w_data(f_wd),
    .re(f_re), .r_data(f_rd), .flush(1'b0), .clr_err(1'b0),
    .empty(f_empty), .full(f_full), .almost_empty(f_ae),
    .almost_full(f_af), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard state for the registered instance
  logic [DW-1:0] q[$];
  int            mc;
  logic          movf, munf;
  logic [DW-1:0] mrd;

  task automatic cyc(input logic w, input logic [DW-1:0] d,
                     input logic r, input logic fl = 1'b0,
                     input logic ce = 1'b0, input logic rs = 1'b0);
    logic rd_ok, wr_ok, popped;
    rst = rs; we = w; w_data = d; re = r;
    flush = fl; clr_err = ce;
    popped = 1'b0;
    @(posedge clk);
    #1;
    rst = 0; we = 0; re = 0; flush = 0; clr_err = 0;
    if (rs) begin
      q.delete(); mc = 0; movf = 0; munf = 0; mrd = '0;
    end else if (fl) begin
      q.delete(); mc = 0;
      if (ce) begin movf = 0; munf = 0; end
    end else begin
      rd_ok = r && (mc != 0);
      wr_ok = w && ((mc != DP) || rd_ok);
      if (rd_ok) begin mrd = q.pop_front(); popped = 1'b1; end
      if (wr_ok) q.push_back(d);
      if (wr_ok && !rd_ok) mc++;
      if (rd_ok && !wr_ok) mc--;
      if (ce) begin
        movf = 0; munf = 0;
      end else begin
        if (w && !wr_ok) movf = 1;
        if (r && !rd_ok) munf = 1;
      end
    end
    chk(popped ? "rd_pop" : "rd_hold", 32'(r_data), 32'(mrd));
    chk("count",  32'(count),  32'(mc));
    chk("empty",  32'(empty),  32'(mc == 0));
    chk("full",   32'(full),   32'(mc == DP));
    chk("aempty", 32'(aempty), 32'(mc <= AE));
    chk("afull",  32'(afull),  32'(mc >= AF));
    chk("ovf",    32'(ovf),    32'(movf));
    chk("unf",    32'(unf),    32'(munf));
  endtask

  logic [DW-1:0] fq[$];

  task automatic fcyc(input logic w, input logic [DW-1:0] d,
                      input logic r, input logic rs = 1'b0);
    f_rst = rs; f_we = w; f_wd = d; f_re = r;
    @(posedge clk);
    #1;
    f_rst = 0; f_we = 0; f_re = 0;
    if (rs) fq.delete();
    else begin
      if (r && fq.size() != 0) void'(fq.pop_front());
      if (w) fq.push_back(d);
    end
    chk("f_count", 32'(f_count), 32'(fq.size()));
    chk("f_empty", 32'(f_empty), 32'(fq.size() == 0));
    if (fq.size() != 0) chk("f_rdata", 32'(f_rd), 32'(fq[0]));
  endtask

  initial begin
    rst = 1; we = 0; re = 0; flush = 0; clr_err = 0; w_data = '0;
    f_rst = 1; f_we = 0; f_re = 0; f_wd = '0;
    mc = 0; movf = 0; munf = 0; mrd = '0;

    // reset / basic
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 8'(i), 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1);

    // fill, thresholds, drop, wrap
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h10 + i), 0);
    cyc(1, 8'h99, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 8'(8'h20 + i), 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1);

    // full pass-through
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h40 + i), 0);
    cyc(1, 8'hAA, 1);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1);
    chk("aa_last", 32'(r_data), 32'h0000_00AA);

    // empty edge cases
    cyc(0, 0, 1);
    cyc(1, 8'h5C, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1, 0, 1);

    // flush and reset mid-stream
    for (int i = 0; i < 17; i++) cyc(1, 8'(8'h60 + i), 0);
    for (int i = 0; i < 11; i++) cyc(0, 0, 1);
    cyc(1, 8'hEE, 0, 1);
    cyc(1, 8'h77, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // FWFT instance
    fcyc(0, 0, 0, 1);
    fcyc(1, 8'h33, 0);
    chk("f_head33", 32'(f_rd), 32'h33);
    fcyc(1, 8'h44, 0);
    fcyc(0, 0, 1);
    chk("f_head44", 32'(f_rd), 32'h44);
    fcyc(0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
